// File: rtl/nn_pkg.sv
// Shared types and helpers for the output neuron MAC.
// FSM encoding, default scale and a signed saturation helper.
package nn_pkg;

    localparam int FRAC_W_DEF = 7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (w - 1));
        if (v > mx)
            return mx;
        else if (v < mn)
            return mn;
        else
            return v;
    endfunction

endpackage

// File: rtl/output_neuron_mac_if.sv
// Pair-input and result-output handshakes of the output neuron.
// master = producer/consumer side, slave = neuron side.
interface output_neuron_mac_if #(
    parameter int X_W   = 10,
    parameter int W_W   = 8,
    parameter int ACC_W = 21
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [X_W-1:0]          x_i;
    logic [W_W-1:0]          w_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic signed [ACC_W-1:0] final_o;
    logic [2*ACC_W-1:0]      loss_o;

    modport master (
        output in_valid_i, x_i, w_i, out_ready_i,
        input  in_ready_o, out_valid_o, final_o, loss_o
    );

    modport slave (
        input  in_valid_i, x_i, w_i, out_ready_i,
        output in_ready_o, out_valid_o, final_o, loss_o
    );
endinterface

// File: rtl/nn_sat_sq.sv
// Finishing stage: saturate, optional ReLU, error vs target, square.
// Purely combinational; the top registers its outputs.
module nn_sat_sq
    import nn_pkg::*;
#(
    parameter int SW      = 25,
    parameter int ACC_W   = 21,
    parameter int TGT_W   = 4,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int RELU_EN = 0
) (
    input  logic signed [SW-1:0]    i_sum,
    input  logic [TGT_W-1:0]        i_target,
    output logic signed [ACC_W-1:0] o_final,
    output logic [2*ACC_W-1:0]      o_loss
);
    logic signed [ACC_W-1:0]   w_r;
    logic signed [ACC_W-1:0]   w_relu;
    logic signed [ACC_W-1:0]   w_err;
    logic signed [2*ACC_W-1:0] w_sq;

    assign w_r = ACC_W'(sat_signed(64'(i_sum), ACC_W));

    assign w_relu = (RELU_EN != 0 && w_r[ACC_W-1]) ? '0 : w_r;

    // Target is an integer; shift it onto the product scale first.
    assign w_err = ACC_W'(sat_signed(
        64'(w_relu) - $signed(64'(i_target) << FRAC_W), ACC_W));

    assign w_sq = (2*ACC_W)'(w_err) * (2*ACC_W)'(w_err);

    assign o_final = w_relu;
    assign o_loss  = w_sq;
endmodule

// File: rtl/output_neuron_mac.sv
// Time-multiplexed output neuron: one multiplier, N_IN beats per inference.
// Accumulate, add bias, saturate, and report squared error to backprop.
module output_neuron_mac
    import nn_pkg::*;
#(
    parameter int N_IN    = 9,
    parameter int X_W     = 10,
    parameter int W_W     = 8,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int ACC_W   = 21,
    parameter int TGT_W   = 4,
    parameter int RELU_EN = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic signed [ACC_W-1:0] bias_i,
    input  logic [TGT_W-1:0]        target_i,
    output logic                    busy_o,
    output_neuron_mac_if.slave      bus
);
    localparam int AW = X_W + W_W + $clog2(N_IN) + 2;
    localparam int PW = X_W + W_W + 1;
    localparam int SW = ((AW > ACC_W) ? AW : ACC_W) + 1;
    localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_IN - 1);

    state_t                  r_state;
    logic signed [AW-1:0]    r_acc;
    logic [CW-1:0]           r_cnt;
    logic signed [ACC_W-1:0] r_bias;
    logic [TGT_W-1:0]        r_tgt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_final;
    logic [2*ACC_W-1:0]      r_loss;

    logic signed [PW-1:0]    w_prod;
    logic signed [SW-1:0]    w_sum;
    logic signed [ACC_W-1:0] w_final;
    logic [2*ACC_W-1:0]      w_loss;
    logic                    w_beat;

    // Activation is unsigned: widen with a zero MSB before the signed multiply.
    assign w_prod = PW'($signed({1'b0, bus.x_i})) * PW'($signed(bus.w_i));
    assign w_sum  = SW'(r_acc) + SW'(r_bias);
    assign w_beat = bus.in_valid_i & r_in_ready;

    nn_sat_sq #(
        .SW      (SW),
        .ACC_W   (ACC_W),
        .TGT_W   (TGT_W),
        .FRAC_W  (FRAC_W),
        .RELU_EN (RELU_EN)
    ) u_sat_sq (
        .i_sum    (w_sum),
        .i_target (r_tgt),
        .o_final  (w_final),
        .o_loss   (w_loss)
    );

    // Control FSM with accumulator, beat counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_bias      <= '0;
            r_tgt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_final     <= '0;
            r_loss      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_bias     <= bias_i;
                        r_tgt      <= target_i;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_beat) begin
                        r_acc <= r_acc + AW'(w_prod);
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_LAST) begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_FIN;
                        end
                    end
                end
                S_FIN: begin
                    r_final     <= w_final;
                    r_loss      <= w_loss;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready_o  = r_in_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.final_o     = r_final;
    assign bus.loss_o      = r_loss;
    assign busy_o          = (r_state != S_IDLE);
endmodule
